// File: rtl/router_input_buffer_if.sv
// Handshake bundle between a router input port and its input buffer.
// The master side feeds flits and flow-control strobes; the slave side is the buffer.
interface router_input_buffer_if #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4
) ();
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              wr_en;
  logic [FLIT_W-1:0] flit_in;
  logic              full;
  logic              rd_en;
  logic              en;
  logic              empty;
  logic [FLIT_W-1:0] flit_out;
  logic              valid;
  logic [CNT_W-1:0]  count;
  logic              ovf_err;

  modport master (
    output wr_en, flit_in, rd_en, en,
    input  full, empty, flit_out, valid, count, ovf_err
  );

  modport slave (
    input  wr_en, flit_in, rd_en, en,
    output full, empty, flit_out, valid, count, ovf_err
  );
endinterface

// File: rtl/router_input_buffer.sv
// Per-port router input buffer: a DEPTH-entry synchronous FIFO feeding a single
// flit pipeline register that flow control advances with en/rd_en.
module router_input_buffer #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  router_input_buffer_if.slave       bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rp_q, rp_d, wp_q, wp_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [FLIT_W-1:0] flit_out_q, flit_out_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              full, empty, push, pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  // A pop needs en as well, so the FIFO never releases a flit the register misses.
  assign push  = bus.wr_en & ~full;
  assign pop   = bus.rd_en & bus.en & ~empty;

  always_comb begin
    rp_d       = rp_q;
    wp_d       = wp_q;
    count_d    = count_q;
    flit_out_d = flit_out_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;

    if (bus.wr_en && full) begin
      ovf_d = 1'b1;
    end

    if (push) begin
      wp_d = (wp_q == PTR_W'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
    end

    if (pop) begin
      rp_d = (rp_q == PTR_W'(DEPTH - 1)) ? '0 : rp_q + 1'b1;
    end

    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    if (bus.en) begin
      valid_d = pop;
      if (pop) begin
        flit_out_d = mem_q[rp_q];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp_q       <= '0;
      wp_q       <= '0;
      count_q    <= '0;
      flit_out_q <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rp_q       <= rp_d;
      wp_q       <= wp_d;
      count_q    <= count_d;
      flit_out_q <= flit_out_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wp_q] <= bus.flit_in;
    end
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.flit_out = flit_out_q;
  assign bus.valid    = valid_q;
  assign bus.ovf_err  = ovf_q;
endmodule
